// File: rtl/pds_pkg.sv
// Shared types and constants for the 68030-to-PDS bus-cycle engine.
// Imported by the synchroniser and the cycle engine.
package pds_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DT,
        E_LOW,
        E_HIGH,
        ACK,
        BERR
    } cycleState_t;

    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    localparam logic [2:0] FC_CPU      = 3'h7;
    localparam logic [3:0] IACK_REGION = 4'hF;

    // Active-high {upper, lower} data strobe selection.
    function automatic logic [1:0] laneSelect(
        input logic       rnw,
        input logic [1:0] size,
        input logic       a0
    );
        logic upper;
        logic lower;
        upper = rnw | ~a0;
        lower = rnw | a0 | (size != SIZ_BYTE);
        return {upper, lower};
    endfunction

endpackage

// File: rtl/pds_sync.sv
// Multi-stage synchroniser for one asynchronous PDS input,
// with single-cycle rise and fall pulses on the synced level.
module pds_sync
    import pds_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic cpuClock,
    input  logic npdsReset,
    input  logic asyncIn,
    output logic syncOut,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              last;

    // Shift the input through the chain; keep the previous synced level.
    always_ff @(posedge cpuClock or negedge npdsReset) begin
        if (!npdsReset) begin
            chain <= {STAGES{RESET_VAL}};
            last  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], asyncIn};
            last  <= chain[STAGES-1];
        end
    end

    assign syncOut = chain[STAGES-1];
    assign rise    = syncOut & ~last;
    assign fall    = ~syncOut & last;

endmodule

// File: rtl/pds_cycle_engine.sv
// 68030-to-16-bit PDS bus-cycle engine: strobes, E-clock cycles,
// autovectored IACK and a bus-error watchdog from one state machine.
module pds_cycle_engine
    import pds_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] PORT16_MASK    = 16'hFFE0
) (
    input  logic       cpuClock,
    input  logic       npdsReset,
    input  logic       busOwned,
    input  logic       ncpuAS,
    input  logic       ncpuDS,
    input  logic       cpuRnW,
    input  logic [1:0] cpuSize,
    input  logic       cpuA0,
    input  logic [3:0] cpuAddrHi,
    input  logic [2:0] cpuFC,
    input  logic       npdsDtack,
    input  logic       npdsVpa,
    input  logic       pdsClockE,
    output logic       npdsAs,
    output logic       npdsUds,
    output logic       npdsLds,
    output logic       npdsVma,
    output logic [1:0] ncpuDsack,
    output logic       ncpuAvec,
    output logic       ncpuBerr,
    output logic       nbufHiEn,
    output logic       nbufLoEn,
    output logic       bufDDir
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

    cycleState_t state;
    cycleState_t nextState;

    logic [CW-1:0] watchdog;
    logic          isIack;
    logic          viaVpa;
    logic          eRiseSeen;
    logic [3:0]    regionHi;

    logic dtSync;
    logic dtRise;
    logic dtFall;
    logic vpaSync;
    logic vpaRise;
    logic vpaFall;
    logic eSync;
    logic eRise;
    logic eFall;

    logic       claim;
    logic       timeout;
    logic       inStrobe;
    logic       inBuf;
    logic       autoVec;
    logic [1:0] lanes;

    logic unusedSignals;
    assign unusedSignals = ^{ncpuDS, dtRise, dtFall, vpaRise, vpaFall};

    pds_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uDtack (
        .cpuClock (cpuClock),
        .npdsReset(npdsReset),
        .asyncIn  (npdsDtack),
        .syncOut  (dtSync),
        .rise     (dtRise),
        .fall     (dtFall)
    );

    pds_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uVpa (
        .cpuClock (cpuClock),
        .npdsReset(npdsReset),
        .asyncIn  (npdsVpa),
        .syncOut  (vpaSync),
        .rise     (vpaRise),
        .fall     (vpaFall)
    );

    pds_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uClockE (
        .cpuClock (cpuClock),
        .npdsReset(npdsReset),
        .asyncIn  (pdsClockE),
        .syncOut  (eSync),
        .rise     (eRise),
        .fall     (eFall)
    );

    assign claim = ~ncpuAS & busOwned &
                   ((cpuFC != FC_CPU) | (cpuAddrHi == IACK_REGION));
    assign timeout = (watchdog == TERMINAL);

    // State register.
    always_ff @(posedge cpuClock or negedge npdsReset) begin
        if (!npdsReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state: abort > DTACK > timeout > VPA.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (claim) nextState = START;
            end
            START: begin
                if (ncpuAS)       nextState = IDLE;
                else if (timeout) nextState = BERR;
                else              nextState = WAIT_DT;
            end
            WAIT_DT: begin
                if (ncpuAS)        nextState = IDLE;
                else if (!dtSync)  nextState = ACK;
                else if (timeout)  nextState = BERR;
                else if (!vpaSync) nextState = E_LOW;
            end
            E_LOW: begin
                if (ncpuAS)       nextState = IDLE;
                else if (timeout) nextState = BERR;
                else if (!eSync)  nextState = E_HIGH;
            end
            E_HIGH: begin
                if (ncpuAS)                  nextState = IDLE;
                else if (timeout)            nextState = BERR;
                else if (eRiseSeen && eFall) nextState = ACK;
            end
            ACK, BERR: begin
                if (ncpuAS) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Watchdog and per-cycle context captured while idle.
    always_ff @(posedge cpuClock or negedge npdsReset) begin
        if (!npdsReset) begin
            watchdog  <= '0;
            isIack    <= 1'b0;
            viaVpa    <= 1'b0;
            eRiseSeen <= 1'b0;
            regionHi  <= '0;
        end else begin
            if (state == IDLE) begin
                watchdog <= '0;
                isIack   <= (cpuFC == FC_CPU);
                regionHi <= cpuAddrHi;
                viaVpa   <= 1'b0;
            end else begin
                if (inStrobe) watchdog <= watchdog + 1'b1;
                if (state == WAIT_DT && nextState == E_LOW) viaVpa <= 1'b1;
            end
            if (state != E_HIGH) eRiseSeen <= 1'b0;
            else if (eRise)      eRiseSeen <= 1'b1;
        end
    end

    // Output decode from the current state.
    always_comb begin
        lanes    = laneSelect(cpuRnW, cpuSize, cpuA0);
        inStrobe = (state == START) | (state == WAIT_DT) |
                   (state == E_LOW) | (state == E_HIGH);
        inBuf    = inStrobe | (state == ACK);
        autoVec  = (state == ACK) & isIack & viaVpa;
        npdsAs   = ~inBuf;
        npdsUds  = ~(inStrobe & lanes[1]);
        npdsLds  = ~(inStrobe & lanes[0]);
        npdsVma  = ~(state == E_HIGH);
        nbufHiEn = ~(inBuf & lanes[1]);
        nbufLoEn = ~(inBuf & lanes[0]);
        ncpuAvec = ~autoVec;
        ncpuBerr = ~(state == BERR);
        bufDDir  = cpuRnW;
        ncpuDsack = 2'b11;
        if (state == ACK && !autoVec) begin
            ncpuDsack = PORT16_MASK[regionHi] ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: tb/tb_pds_cycle_engine.sv
// Self-checking bench for pds_cycle_engine with a spec-level
// model of strobe lanes, port sizing and acknowledge timing.
module tb_pds_cycle_engine;

    localparam int          S    = 2;
    localparam int          T    = 16;
    localparam logic [15:0] MASK = 16'hFFE0;

    logic       cpuClock;
    logic       npdsReset;
    logic       busOwned;
    logic       ncpuAS;
    logic       ncpuDS;
    logic       cpuRnW;
    logic [1:0] cpuSize;
    logic       cpuA0;
    logic [3:0] cpuAddrHi;
    logic [2:0] cpuFC;
    logic       npdsDtack;
    logic       npdsVpa;
    logic       pdsClockE;
    logic       npdsAs;
    logic       npdsUds;
    logic       npdsLds;
    logic       npdsVma;
    logic [1:0] ncpuDsack;
    logic       ncpuAvec;
    logic       ncpuBerr;
    logic       nbufHiEn;
    logic       nbufLoEn;
    logic       bufDDir;

    int checks;
    int errors;

    pds_cycle_engine #(
        .SYNC_STAGES   (S),
        .TIMEOUT_CYCLES(T),
        .PORT16_MASK   (MASK)
    ) dut (
        .cpuClock (cpuClock),
        .npdsReset(npdsReset),
        .busOwned (busOwned),
        .ncpuAS   (ncpuAS),
        .ncpuDS   (ncpuDS),
        .cpuRnW   (cpuRnW),
        .cpuSize  (cpuSize),
        .cpuA0    (cpuA0),
        .cpuAddrHi(cpuAddrHi),
        .cpuFC    (cpuFC),
        .npdsDtack(npdsDtack),
        .npdsVpa  (npdsVpa),
        .pdsClockE(pdsClockE),
        .npdsAs   (npdsAs),
        .npdsUds  (npdsUds),
        .npdsLds  (npdsLds),
        .npdsVma  (npdsVma),
        .ncpuDsack(ncpuDsack),
        .ncpuAvec (ncpuAvec),
        .ncpuBerr (ncpuBerr),
        .nbufHiEn (nbufHiEn),
        .nbufLoEn (nbufLoEn),
        .bufDDir  (bufDDir)
    );

    initial cpuClock = 1'b0;
    always #5 cpuClock = ~cpuClock;

    // Free-running E clock, 4 cpuClock periods, off the active edge.
    initial begin
        pdsClockE = 1'b1;
        forever begin
            repeat (2) @(posedge cpuClock);
            #3 pdsClockE = ~pdsClockE;
        end
    end

    function automatic logic allNegated();
        return npdsAs & npdsUds & npdsLds & npdsVma & ncpuAvec &
               ncpuBerr & nbufHiEn & nbufLoEn & (ncpuDsack == 2'b11);
    endfunction

    function automatic logic [9:0] outVec();
        return {npdsAs, npdsUds, npdsLds, npdsVma, ncpuDsack,
                ncpuAvec, ncpuBerr, nbufHiEn, nbufLoEn};
    endfunction

    task automatic tick();
        @(posedge cpuClock);
        #1;
    endtask

    task automatic test_reset();
        npdsReset = 1'b0;
        busOwned  = 1'b1;
        ncpuAS    = 1'b1;
        ncpuDS    = 1'b1;
        cpuRnW    = 1'b1;
        cpuSize   = 2'b00;
        cpuA0     = 1'b0;
        cpuAddrHi = 4'h0;
        cpuFC     = 3'h1;
        npdsDtack = 1'b1;
        npdsVpa   = 1'b1;
        repeat (3) tick();
        checks++;
        if (allNegated() !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all ones", outVec());
        end
        checks++;
        if (bufDDir !== 1'b1) begin
            errors++;
            $display("FAIL reset_ddir_rd: got %b want 1", bufDDir);
        end
        cpuRnW = 1'b0;
        #1;
        checks++;
        if (bufDDir !== 1'b0) begin
            errors++;
            $display("FAIL reset_ddir_wr: got %b want 0", bufDDir);
        end
        cpuRnW    = 1'b1;
        npdsReset = 1'b1;
        repeat (S + 2) tick();
    endtask

    // One DTACK-terminated (or timed-out) cycle; dly = ticks after
    // START is seen before DTACK is driven low.
    task automatic test_dtack_cycle(
        input logic       rnw,
        input logic [1:0] size,
        input logic       a0,
        input logic [3:0] hi,
        input logic [2:0] fc,
        input int         dly,
        input logic       dropOwn
    );
        logic       expU;
        logic       expL;
        logic [1:0] expDs;
        int         ackEdge;
        int         evEdge;
        logic       berrCase;
        logic       early;
        expU     = rnw | ~a0;
        expL     = rnw | a0 | (size != 2'b01);
        expDs    = MASK[hi] ? 2'b01 : 2'b10;
        ackEdge  = dly + S + 1;
        berrCase = (ackEdge > T);
        evEdge   = berrCase ? T : ackEdge;
        cpuRnW    = rnw;
        cpuSize   = size;
        cpuA0     = a0;
        cpuAddrHi = hi;
        cpuFC     = fc;
        npdsDtack = 1'b1;
        npdsVpa   = 1'b1;
        ncpuAS    = 1'b0;
        ncpuDS    = 1'b0;
        tick();
        checks++;
        if ({npdsAs, npdsUds, npdsLds} !== {1'b0, ~expU, ~expL}) begin
            errors++;
            $display("FAIL start_strobes: got %b want %b",
                     {npdsAs, npdsUds, npdsLds}, {1'b0, ~expU, ~expL});
        end
        checks++;
        if ({nbufHiEn, nbufLoEn} !== {~expU, ~expL}) begin
            errors++;
            $display("FAIL start_buffers: got %b want %b",
                     {nbufHiEn, nbufLoEn}, {~expU, ~expL});
        end
        early = 1'b0;
        for (int j = 1; j <= evEdge; j++) begin
            if (j == dly + 1) npdsDtack = 1'b0;
            if (j == 2 && dropOwn) busOwned = 1'b0;
            tick();
            if (j < evEdge) begin
                if (ncpuDsack != 2'b11 || !ncpuBerr || npdsAs ||
                    {npdsUds, npdsLds} != {~expU, ~expL})
                    early = 1'b1;
            end
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL wait_phase: got early/bad outputs want steady dly=%0d",
                     dly);
        end
        checks++;
        if (berrCase) begin
            if ({ncpuDsack, ncpuBerr} !== 3'b110) begin
                errors++;
                $display("FAIL timeout_berr: got dsack=%b berr=%b want 11/0 dly=%0d",
                         ncpuDsack, ncpuBerr, dly);
            end
        end else begin
            if ({ncpuDsack, ncpuBerr, ncpuAvec} !== {expDs, 2'b11}) begin
                errors++;
                $display("FAIL dsack_edge: got dsack=%b berr=%b want %b/1 dly=%0d",
                         ncpuDsack, ncpuBerr, expDs, dly);
            end
        end
        repeat (2) tick();
        checks++;
        if ({ncpuDsack, ncpuBerr} !== (berrCase ? 3'b110 : {expDs, 1'b1})) begin
            errors++;
            $display("FAIL ack_hold: got dsack=%b berr=%b", ncpuDsack, ncpuBerr);
        end
        ncpuAS = 1'b1;
        ncpuDS = 1'b1;
        tick();
        checks++;
        if (allNegated() !== 1'b1) begin
            errors++;
            $display("FAIL as_release: got %b want all ones", outVec());
        end
        npdsDtack = 1'b1;
        busOwned  = 1'b1;
        repeat (S + 2) tick();
    endtask

    task automatic test_unclaimed(input logic [2:0] fc, input logic [3:0] hi,
                                  input logic own);
        logic seen;
        busOwned  = own;
        cpuFC     = fc;
        cpuAddrHi = hi;
        ncpuAS    = 1'b0;
        seen      = 1'b0;
        repeat (6) begin
            tick();
            if (!allNegated()) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL unclaimed: got activity want idle fc=%0d hi=%h own=%b",
                     fc, hi, own);
        end
        ncpuAS   = 1'b1;
        busOwned = 1'b1;
        repeat (2) tick();
    endtask

    // VPA-terminated 6800-style cycle, autovectored when IACK.
    task automatic test_vpa_cycle(input logic [2:0] fc, input logic [3:0] hi);
        logic       iack;
        logic       vmaSeen;
        logic       fallAfterVma;
        logic       prevE;
        logic       done;
        logic [1:0] expDs;
        iack      = (fc == 3'h7) && (hi == 4'hF);
        expDs     = iack ? 2'b11 : (MASK[hi] ? 2'b01 : 2'b10);
        cpuFC     = fc;
        cpuAddrHi = hi;
        cpuRnW    = 1'b1;
        cpuSize   = 2'b01;
        cpuA0     = 1'b1;
        npdsVpa   = 1'b0;
        ncpuAS    = 1'b0;
        vmaSeen      = 1'b0;
        fallAfterVma = 1'b0;
        done         = 1'b0;
        prevE        = pdsClockE;
        for (int j = 0; j < 40 && !done; j++) begin
            tick();
            if (vmaSeen && prevE && !pdsClockE) fallAfterVma = 1'b1;
            if (!npdsVma) vmaSeen = 1'b1;
            prevE = pdsClockE;
            if (!ncpuAvec || ncpuDsack != 2'b11 || !ncpuBerr) done = 1'b1;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL vpa_done: got no acknowledge want ack within 40");
        end
        checks++;
        if ({vmaSeen, fallAfterVma} !== 2'b11) begin
            errors++;
            $display("FAIL vpa_vma: got seen=%b fall=%b want 1/1",
                     vmaSeen, fallAfterVma);
        end
        checks++;
        if ({ncpuAvec, ncpuDsack, ncpuBerr, npdsVma} !==
            {~iack, expDs, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL vpa_ack: got avec=%b dsack=%b berr=%b vma=%b want %b/%b/1/1",
                     ncpuAvec, ncpuDsack, ncpuBerr, npdsVma, ~iack, expDs);
        end
        ncpuAS  = 1'b1;
        npdsVpa = 1'b1;
        tick();
        checks++;
        if (allNegated() !== 1'b1) begin
            errors++;
            $display("FAIL vpa_release: got %b want all ones", outVec());
        end
        repeat (S + 2) tick();
    endtask

    task automatic test_reset_mid_cycle();
        logic found;
        logic spurious;
        cpuFC     = 3'h7;
        cpuAddrHi = 4'hF;
        cpuRnW    = 1'b1;
        npdsVpa   = 1'b0;
        ncpuAS    = 1'b0;
        found     = 1'b0;
        for (int j = 0; j < 40 && !found; j++) begin
            tick();
            if (!npdsVma) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach_ehigh: got no VMA want VMA low");
        end
        #2 npdsReset = 1'b0;
        #1;
        checks++;
        if ({allNegated(), bufDDir} !== 2'b11) begin
            errors++;
            $display("FAIL rst_async: got %b ddir=%b want all ones", outVec(),
                     bufDDir);
        end
        ncpuAS  = 1'b1;
        npdsVpa = 1'b1;
        tick();
        npdsReset = 1'b1;
        spurious  = 1'b0;
        repeat (8) begin
            tick();
            if (!allNegated()) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got activity want idle");
        end
    endtask

    task automatic test_random_cycles();
        logic [2:0] fcTab [5];
        logic [2:0] fc;
        logic [3:0] hi;
        fcTab = '{3'h1, 3'h2, 3'h5, 3'h6, 3'h7};
        for (int i = 0; i < 30; i++) begin
            fc = fcTab[$urandom_range(0, 4)];
            hi = (fc == 3'h7) ? 4'hF : 4'($urandom_range(0, 15));
            test_dtack_cycle(1'($urandom), 2'($urandom), 1'($urandom), hi, fc,
                             $urandom_range(0, 15), 1'($urandom));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_dtack_cycle(1'b0, 2'b10, 1'b0, 4'h5, 3'h1, 5, 1'b0);
        test_dtack_cycle(1'b0, 2'b01, 1'b1, 4'h0, 3'h1, 2, 1'b0);
        test_dtack_cycle(1'b0, 2'b01, 1'b0, 4'h3, 3'h2, 0, 1'b0);
        test_dtack_cycle(1'b1, 2'b00, 1'b0, 4'h8, 3'h6, 100, 1'b0);
        test_dtack_cycle(1'b1, 2'b10, 1'b0, 4'h9, 3'h5, 13, 1'b0);
        test_dtack_cycle(1'b1, 2'b10, 1'b0, 4'h9, 3'h5, 14, 1'b0);
        test_dtack_cycle(1'b0, 2'b11, 1'b1, 4'h1, 3'h1, 3, 1'b1);
        test_unclaimed(3'h7, 4'h2, 1'b1);
        test_unclaimed(3'h1, 4'h5, 1'b0);
        test_vpa_cycle(3'h7, 4'hF);
        test_vpa_cycle(3'h5, 4'hE);
        test_vpa_cycle(3'h1, 4'h2);
        test_random_cycles();
        test_reset_mid_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
